// File: rtl/fib_bcd_display.sv
// rtl/fib_bcd_display.sv - Fibonacci value to 5-digit BCD and multiplexed 7-segment display
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   f_valid   input value valid, sampled each rising edge
//   f_out     16-bit unsigned value to display
//   d_busy    high while a conversion is in progress (CONV or LOAD)
//   bcd_valid one-clock pulse when bcd_out takes a new value
//   bcd_out   packed BCD of the displayed value, digit 4 most significant
//   an        active-low one-hot digit enables, an[0] least significant digit
//   seg       active-low segments, seg[6:0] = gfedcba, seg[7] = dp (always 1)

module fib_bcd_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [15:0] f_out,
    output logic        d_busy,
    output logic        bcd_valid,
    output logic [19:0] bcd_out,
    output logic [4:0]  an,
    output logic [7:0]  seg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t      state, state_next;
    logic [15:0] bin, bin_next;
    logic [19:0] bcd, bcd_next, bcd_adj;
    logic [3:0]  step, step_next;
    logic [15:0] pend_val, pend_val_next;
    logic        pend_full, pend_full_next;
    logic [19:0] bcd_out_next;
    logic        bcd_valid_next;
    logic        d_busy_next;

    logic [CW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [3:0]    cur_nib;
    logic          cur_blank;
    logic [4:0]    an_next;
    logic [7:0]    seg_next;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                         : bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            step      <= '0;
            pend_val  <= '0;
            pend_full <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            d_busy    <= 1'b0;
        end else begin
            state     <= state_next;
            bin       <= bin_next;
            bcd       <= bcd_next;
            step      <= step_next;
            pend_val  <= pend_val_next;
            pend_full <= pend_full_next;
            bcd_out   <= bcd_out_next;
            bcd_valid <= bcd_valid_next;
            d_busy    <= d_busy_next;
        end
    end

    always_comb begin
        state_next     = state;
        bin_next       = bin;
        bcd_next       = bcd;
        step_next      = step;
        pend_val_next  = pend_val;
        pend_full_next = pend_full;
        bcd_out_next   = bcd_out;
        bcd_valid_next = 1'b0;
        d_busy_next    = d_busy;

        case (state)
            IDLE: begin
                if (f_valid) begin
                    bin_next    = f_out;
                    bcd_next    = '0;
                    step_next   = '0;
                    state_next  = CONV;
                    d_busy_next = 1'b1;
                end
            end
            CONV: begin
                bcd_next  = {bcd_adj[18:0], bin[15]};
                bin_next  = {bin[14:0], 1'b0};
                step_next = step + 4'd1;
                if (step == 4'd15) begin
                    state_next = LOAD;
                end
                // Single-entry holding slot; only the newest arrival survives.
                if (f_valid) begin
                    pend_val_next  = f_out;
                    pend_full_next = 1'b1;
                end
            end
            LOAD: begin
                bcd_out_next   = bcd;
                bcd_valid_next = 1'b1;
                pend_full_next = 1'b0;
                if (f_valid || pend_full) begin
                    // A value arriving in this very cycle is newer than the held one.
                    bin_next    = f_valid ? f_out : pend_val;
                    bcd_next    = '0;
                    step_next   = '0;
                    state_next  = CONV;
                    d_busy_next = 1'b1;
                end else begin
                    state_next  = IDLE;
                    d_busy_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                d_busy_next = 1'b0;
            end
        endcase
    end

    // Display scan runs independently of the conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd4) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        cur_nib   = bcd_out[3:0];
        cur_blank = 1'b0;
        case (digit_idx)
            3'd0: begin
                cur_nib   = bcd_out[3:0];
                cur_blank = 1'b0;
            end
            3'd1: begin
                cur_nib   = bcd_out[7:4];
                cur_blank = (bcd_out[19:4] == 16'd0);
            end
            3'd2: begin
                cur_nib   = bcd_out[11:8];
                cur_blank = (bcd_out[19:8] == 12'd0);
            end
            3'd3: begin
                cur_nib   = bcd_out[15:12];
                cur_blank = (bcd_out[19:12] == 8'd0);
            end
            3'd4: begin
                cur_nib   = bcd_out[19:16];
                cur_blank = (bcd_out[19:16] == 4'd0);
            end
            default: begin
                cur_nib   = 4'd0;
                cur_blank = 1'b1;
            end
        endcase
    end

    always_comb begin
        an_next = ~(5'b00001 << digit_idx);
        if (cur_blank) begin
            seg_next = 8'hFF;
        end else begin
            case (cur_nib)
                4'd0:    seg_next = 8'hC0;
                4'd1:    seg_next = 8'hF9;
                4'd2:    seg_next = 8'hA4;
                4'd3:    seg_next = 8'hB0;
                4'd4:    seg_next = 8'h99;
                4'd5:    seg_next = 8'h92;
                4'd6:    seg_next = 8'h82;
                4'd7:    seg_next = 8'hF8;
                4'd8:    seg_next = 8'h80;
                4'd9:    seg_next = 8'h90;
                default: seg_next = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 5'b11111;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
